// File: rtl/fir_deconv.sv
// fir_deconv: inverse of the 3-tap FIR y[n] = C0*x[n] + C1*x[n-1] + C2*x[n-2].
// Recovers x[n] = C0*(y[n] - C1*x[n-1] - C2*x[n-2]) with a single
// time-multiplexed multiply-accumulate. Each sample takes 4 cycles:
// IDLE (load), MAC1, MAC2, NORM (negate and saturate, emit).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (dominates everything)
//   clear     synchronous: zero the history and err_sat, abort work in flight
//   in_data   signed filtered sample y[n] (IN_W bits)
//   in_valid  in_data is valid
//   in_ready  block can accept a sample this cycle
//   out_data  signed recovered sample x[n] (OUT_W bits), held between results
//   out_valid one-cycle pulse per accepted sample
//   err_sat   sticky: some result had to be saturated
module fir_deconv #(
  parameter int IN_W   = 18,
  parameter int OUT_W  = 8,
  parameter int COEF_W = 8,
  parameter int C0     = -1,
  parameter int C1     = 2,
  parameter int C2     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic signed [IN_W-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  output logic                     err_sat
);

  // Wide enough that y - C1*h1 - C2*h2 can never wrap.
  localparam int ACC_W  = IN_W + COEF_W + OUT_W + 2;
  localparam int PROD_W = COEF_W + OUT_W;

  localparam logic signed [COEF_W-1:0] C1_S = COEF_W'(C1);
  localparam logic signed [COEF_W-1:0] C2_S = COEF_W'(C2);

  // Exact integer recovery needs C0 to be its own inverse.
  generate
    if (C0 != 1 && C0 != -1) begin : g_c0_check
      $error("fir_deconv: C0 must be +1 or -1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MAC1, MAC2, NORM} state_t;

  state_t                     state_reg, state_next;
  logic signed [ACC_W-1:0]    acc_reg;
  logic signed [OUT_W-1:0]    h1_reg, h2_reg;
  logic signed [OUT_W-1:0]    out_data_reg;
  logic                       out_valid_reg;
  logic                       err_sat_reg;

  logic                       take;
  logic signed [COEF_W-1:0]   coef_sel;
  logic signed [OUT_W-1:0]    hist_sel;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    mac_res;
  logic signed [ACC_W-1:0]    norm_r;
  logic signed [OUT_W-1:0]    norm_s;
  logic                       norm_sat;
  logic [ACC_W-OUT_W:0]       norm_top;

  assign in_ready = (state_reg == IDLE) & ~clear & ~rst;
  assign take     = in_valid & in_ready;

  // Shared multiplier: tap 1 in MAC1, tap 2 otherwise.
  assign coef_sel = (state_reg == MAC1) ? C1_S : C2_S;
  assign hist_sel = (state_reg == MAC1) ? h1_reg : h2_reg;
  assign prod     = PROD_W'(coef_sel) * PROD_W'(hist_sel);
  assign mac_res  = acc_reg - ACC_W'(prod);

  // Multiply by C0 (+/-1), then clamp. r fits in OUT_W bits exactly when all
  // bits from the OUT_W-1 position upward are copies of the sign.
  assign norm_r   = (C0 == 1) ? acc_reg : -acc_reg;
  assign norm_top = norm_r[ACC_W-1:OUT_W-1];

  always_comb begin
    norm_sat = 1'b0;
    norm_s   = norm_r[OUT_W-1:0];
    if (!((norm_top == '0) || (norm_top == '1))) begin
      norm_sat = 1'b1;
      norm_s   = norm_r[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = MAC1;
      MAC1:    state_next = MAC2;
      MAC2:    state_next = NORM;
      NORM:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      h1_reg        <= '0;
      h2_reg        <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      err_sat_reg   <= 1'b0;
    end else if (clear) begin
      // out_data deliberately keeps the last emitted value.
      state_reg     <= IDLE;
      acc_reg       <= '0;
      h1_reg        <= '0;
      h2_reg        <= '0;
      out_valid_reg <= 1'b0;
      err_sat_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: if (take) acc_reg <= ACC_W'(in_data);
        MAC1: acc_reg <= mac_res;
        MAC2: acc_reg <= mac_res;
        NORM: begin
          out_data_reg  <= norm_s;
          out_valid_reg <= 1'b1;
          // History holds the emitted (saturated) value.
          h2_reg        <= h1_reg;
          h1_reg        <= norm_s;
          err_sat_reg   <= err_sat_reg | norm_sat;
        end
        default: ;
      endcase
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign err_sat   = err_sat_reg;

endmodule

// File: tb/tb_fir_deconv.sv
module tb_fir_deconv;
  localparam int IN_W  = 18;
  localparam int OUT_W = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     clear;
  logic signed [IN_W-1:0]   in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_valid;
  logic                     err_sat;

  fir_deconv #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(8), .C0(-1), .C1(2), .C2(3)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .err_sat(err_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  // Output monitor: every pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        $display("out: cyc=%0d data=%0d expect=%0d", cyc, out_data, mon_e.data);
        check("out_data", out_data, mon_e.data);
        check("latency", cyc, mon_e.due);
      end
    end
  end

  // Present y, wait for in_ready (bounded), optionally record expectation.
  task automatic send(input int y, input bit push, input int expv);
    int k;
    in_data  = IN_W'(y);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    else if (push) sb.push_back('{expv, cyc + 4});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("drain", sb.size(), 0);
  endtask

  // Clear with in_valid asserted: the sample must not be taken.
  task automatic do_clear();
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = IN_W'(9);
    #1;
    check("clear_ready", in_ready, 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("clear_err", err_sat, 0);
  endtask

  int p1, p2, y, r, s, mh1, mh2, xfers, base;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = IN_W'(7);

    // Reset held two cycles with in_valid high.
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_err", err_sat, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);

    // Exact recovery from zero history.
    send(-5, 1, 5);
    send(13, 1, -3);
    send(2, 1, 7);
    drain();
    check("exact_err", err_sat, 0);

    // Full-range loopback through a C=(-1,2,3) FIR model.
    do_clear();
    p1 = 0; p2 = 0;
    for (int x = -10; x <= 10; x++) begin
      y = -x + 2 * p1 + 3 * p2;
      p2 = p1; p1 = x;
      send(y, 1, x);
    end
    drain();
    check("loop_err", err_sat, 0);

    // Saturation from zero history.
    do_clear();
    send(200, 1, -128);
    drain();
    check("sat_err1", err_sat, 1);
    send(0, 1, -128);
    drain();
    check("sat_err2", err_sat, 1);

    // Clear during MAC2 aborts the sample.
    send(-5, 0, 0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_err", err_sat, 0);
    check("abort_hold", out_data, -128);
    repeat (6) @(negedge clk);
    send(-5, 1, 5);
    drain();

    // Clear with in_valid in IDLE: nothing may come out.
    do_clear();
    repeat (6) @(negedge clk);
    check("clear_no_out", sb.size(), 0);

    // Handshake stall: in_valid high, data changing every cycle.
    do_clear();
    mh1 = 0; mh2 = 0; xfers = 0; base = n_out;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      y = int'($urandom_range(0, 600)) - 300;
      in_data = IN_W'(y);
      if (in_ready) begin
        r = -(y - 2 * mh1 - 3 * mh2);
        s = (r > 127) ? 127 : ((r < -128) ? -128 : r);
        mh2 = mh1; mh1 = s;
        sb.push_back('{s, cyc + 4});
        xfers++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    check("stall_count", n_out - base, xfers);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_deconv.md
Name: fir_deconv

Overview:
- Inverse (deconvolution) block for the 3-tap FIR y[n] = C0*x[n] + C1*x[n-1] + C2*x[n-2].
- Recovers the original 8-bit sample stream from the 18-bit filtered stream using x[n] = C0*(y[n] - C1*x[n-1] - C2*x[n-2]), with C0 restricted to ±1 so recovery is exact in integers.
- Sits downstream of the FIR, e.g. on the receive side of a link or as a loopback checker.
- Uses a time-multiplexed single-MAC datapath: one sample every 4 cycles, with a valid/ready handshake on the input.

Parameters:
- IN_W, 18: signed width of the filtered input y.
- OUT_W, 8: signed width of the recovered output x.
- COEF_W, 8: signed coefficient width.
- C0, -1: tap-0 coefficient; legal values are +1 or -1 only (checked at elaboration).
- C1, 2: tap-1 coefficient.
- C2, 3: tap-2 coefficient.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous; zeroes the history and err_sat, and aborts any operation in flight.
- in_data  in  IN_W  signed filtered sample y[n].
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a sample this cycle.
- out_data  out  OUT_W  signed recovered sample x[n].
- out_valid  out  1  one-cycle pulse; out_data is valid.
- err_sat  out  1  sticky flag; a result was saturated.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, h1=h2=0, acc=0, out_data=0, out_valid=0, err_sat=0.
  - rst dominates clear and in_valid.
  - Reset mid-operation aborts the sample: no out_valid, history zeroed.
- in_ready = (state==IDLE) & ~clear & ~rst. A sample transfers on a rising edge where in_valid & in_ready. in_data is not sampled in any other cycle.
- FSM, one transition per clock:
  - IDLE: on transfer, acc <= sign-extended in_data; go to MAC1. Otherwise hold.
  - MAC1: acc <= acc - C1*h1; go to MAC2.
  - MAC2: acc <= acc - C2*h2; go to NORM.
  - NORM:
    - r = (C0==1) ? acc : -acc.
    - s = r saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - out_data <= s, out_valid <= 1.
    - h2 <= h1, h1 <= s.
    - err_sat <= err_sat | (s != r).
    - Go to IDLE.
- Timing:
  - Transfer at edge E0 gives out_valid high in the cycle after edge E3 (latency 3 edges).
  - in_ready is high again in that same cycle, so back-to-back samples are accepted every 4 cycles.
- out_valid is high for exactly one cycle per accepted sample. out_data holds its value until the next NORM, reset or clear. There is no output backpressure.
- Arithmetic:
  - acc is signed, width IN_W+COEF_W+OUT_W+2; no internal overflow is possible.
  - Products are signed×signed.
  - History stores the saturated value, so the recursion continues from the emitted output.
- clear=1 at an edge:
  - h1=h2=0, err_sat=0, state=IDLE, acc=0; out_valid=0 that cycle.
  - out_data is unchanged.
  - A simultaneous in_valid is not accepted (in_ready is low).
- in_valid held high while busy is ignored; the sample waits until in_ready.
- The recursion is unstable for the default coefficients (poles at 3 and -1). Exact recovery is guaranteed only for y streams produced by the matching FIR from zero history. Any other input converges to saturation and sets err_sat; this is required behaviour, not a fault.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, err_sat=0; in_ready=1 the first cycle after rst drops.
- Exact recovery: y = -5, 13, 2, each presented as soon as in_ready -> out_data = 5, -3, 7; each out_valid exactly 3 edges after its transfer; 4-cycle spacing; err_sat=0.
- Full-range loopback: x = -10..10 through a FIR model (C=-1,2,3), then y fed back-to-back -> 21 outputs equal -10..10 in order; err_sat=0.
- Saturation: from zero history y=200 -> out_data=-128, err_sat=1. Then y=0 -> r=-256, out_data=-128, err_sat stays 1.
- Clear and abort: assert clear in MAC2 of a sample -> no out_valid for it; h1=h2=0, err_sat=0. Next y=-5 -> out_data=5. clear together with in_valid in IDLE -> sample not accepted.
- Handshake stall: in_valid held high continuously with y changing every cycle -> only values present in cycles with in_ready=1 are consumed; out_valid count equals transfer count.
